// File: rtl/cla_pkg.sv
// Shared constants and helpers for the parameterised carry look-ahead adder.
package cla_pkg;

  localparam int unsigned CLA_DEFAULT_N = 8;
  localparam int unsigned CLA_DEFAULT_G = 4;

  // Number of look-ahead groups needed to cover n bits with groups of g bits.
  function automatic int unsigned cla_num_groups(input int unsigned n, input int unsigned g);
    return (n + g - 1) / g;
  endfunction

endpackage

// File: rtl/cla_group.sv
// G-bit first-level look-ahead block: local carries, sum bits, group generate/propagate.
module cla_group #(
  parameter int unsigned G = 4
) (
  input  logic [G-1:0] p,
  input  logic [G-1:0] g,
  input  logic         cin,
  output logic [G-1:0] s,
  output logic         gg,
  output logic         gp
);

  logic [G-1:0] c;
  logic         term;
  logic         carry;

  // Every carry is a flat sum of products of g/p/cin, so no carry feeds another.
  always_comb begin
    c     = '0;
    term  = 1'b0;
    carry = 1'b0;
    gg    = 1'b0;
    for (int unsigned i = 0; i < G; i++) begin
      term = cin;
      for (int unsigned k = 0; k < i; k++) term = term & p[k];
      carry = term;
      for (int unsigned j = 0; j < i; j++) begin
        term = g[j];
        for (int unsigned k = j + 1; k < i; k++) term = term & p[k];
        carry = carry | term;
      end
      c[i] = carry;
    end
    for (int unsigned j = 0; j < G; j++) begin
      term = g[j];
      for (int unsigned k = j + 1; k < G; k++) term = term & p[k];
      gg = gg | term;
    end
  end

  assign gp = &p;
  assign s  = p ^ c;

endmodule

// File: rtl/somador_carry_look_ahead_param.sv
// Two-level carry look-ahead adder with registered sum and carry-out.
// Define CLA_OVERFLOW_EN to add the registered signed-overflow output V.
module somador_carry_look_ahead_param
  import cla_pkg::*;
#(
  parameter int unsigned N = CLA_DEFAULT_N,
  parameter int unsigned G = CLA_DEFAULT_G
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         C_in,
  output logic [N-1:0] S,
  output logic         C_out
`ifdef CLA_OVERFLOW_EN
  , output logic       V
`endif
);

  localparam int unsigned NG = cla_num_groups(N, G);
  localparam int unsigned W  = NG * G;

  logic [W-1:0]  p_pad;
  logic [W-1:0]  g_pad;
  logic [W-1:0]  s_pad;
  logic [W:0]    s_ext;
  logic [NG-1:0] gg_v;
  logic [NG-1:0] gp_v;
  logic [NG:0]   cg;
  logic          term;
  logic          carry;
  logic          unused_hi;

  // Padding bits above N carry p=0, g=0.
  assign p_pad = W'(A ^ B);
  assign g_pad = W'(A & B);

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_group #(.G(G)) u_grp (
      .p   (p_pad[k*G +: G]),
      .g   (g_pad[k*G +: G]),
      .cin (cg[k]),
      .s   (s_pad[k*G +: G]),
      .gg  (gg_v[k]),
      .gp  (gp_v[k])
    );
  end

  always_comb begin
    cg    = '0;
    term  = 1'b0;
    carry = 1'b0;
    for (int unsigned i = 0; i <= NG; i++) begin
      term = C_in;
      for (int unsigned k = 0; k < i; k++) term = term & gp_v[k];
      carry = term;
      for (int unsigned j = 0; j < i; j++) begin
        term = gg_v[j];
        for (int unsigned k = j + 1; k < i; k++) term = term & gp_v[k];
        carry = carry | term;
      end
      cg[i] = carry;
    end
  end

  // Bit N of s_ext is the carry out of bit N-1: a padded bit has p=0 so its sum
  // equals its carry-in, and without padding it is the top group carry.
  assign s_ext     = {cg[NG], s_pad};
  assign unused_hi = ^s_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      S     <= '0;
      C_out <= 1'b0;
    end else begin
      S     <= s_ext[N-1:0];
      C_out <= s_ext[N];
    end
  end

`ifdef CLA_OVERFLOW_EN
  logic c_msb_in;

  assign c_msb_in = s_ext[N-1] ^ p_pad[N-1];

  always_ff @(posedge clk) begin
    if (rst) V <= 1'b0;
    else     V <= c_msb_in ^ s_ext[N];
  end
`endif

endmodule

// File: tb/tb_somador_carry_look_ahead_param.sv
// Self-checking bench: directed vectors plus random sweeps at N=8/G=4 and N=13/G=4.
module tb_somador_carry_look_ahead_param;

  logic        clk;
  logic        rst;
  logic [7:0]  a8, b8, s8;
  logic        ci8, co8;
  logic [12:0] a13, b13, s13;
  logic        ci13, co13;
`ifdef CLA_OVERFLOW_EN
  logic        v8, v13;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  somador_carry_look_ahead_param #(.N(8), .G(4)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .A     (a8),
    .B     (b8),
    .C_in  (ci8),
    .S     (s8),
    .C_out (co8)
`ifdef CLA_OVERFLOW_EN
    , .V   (v8)
`endif
  );

  somador_carry_look_ahead_param #(.N(13), .G(4)) dut13 (
    .clk   (clk),
    .rst   (rst),
    .A     (a13),
    .B     (b13),
    .C_in  (ci13),
    .S     (s13),
    .C_out (co13)
`ifdef CLA_OVERFLOW_EN
    , .V   (v13)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Signed overflow: operands share a sign that the result does not.
  function automatic logic ovf(input logic sa, input logic sb, input logic ss);
    return (sa == sb) && (ss != sa);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dir8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [7:0] es, input logic ec, input logic ev);
    a8 = a; b8 = b; ci8 = c;
    tick();
    chk({tag, "_s"}, 64'(s8), 64'(es));
    chk({tag, "_c"}, 64'(co8), 64'(ec));
`ifdef CLA_OVERFLOW_EN
    chk({tag, "_v"}, 64'(v8), 64'(ev));
`endif
  endtask

  logic [8:0]  m9, prev9;
  logic [13:0] m14, prev14;

  initial begin
    rst = 1'b1;
    a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b0;
    a13 = 13'h1FFF; b13 = 13'h0001; ci13 = 1'b0;
    tick();
    chk("rst_s8", 64'(s8), 64'h0);
    chk("rst_c8", 64'(co8), 64'h0);
    chk("rst_s13", 64'(s13), 64'h0);
    chk("rst_c13", 64'(co13), 64'h0);
`ifdef CLA_OVERFLOW_EN
    chk("rst_v8", 64'(v8), 64'h0);
`endif
    rst = 1'b0;
    tick();
    chk("rel_s8", 64'(s8), 64'h00);
    chk("rel_c8", 64'(co8), 64'h1);
    chk("rel_s13", 64'(s13), 64'h0000);
    chk("rel_c13", 64'(co13), 64'h1);

    dir8("bb_dd", 8'hBB, 8'hDD, 1'b0, 8'h98, 1'b1, 1'b0);
    dir8("55_33", 8'h55, 8'h33, 1'b0, 8'h88, 1'b0, 1'b1);
    dir8("prop0", 8'hEE, 8'h11, 1'b0, 8'hFF, 1'b0, 1'b0);
    dir8("prop1", 8'hEE, 8'h11, 1'b1, 8'h00, 1'b1, 1'b0);
    dir8("cin", 8'h99, 8'h66, 1'b1, 8'h00, 1'b1, 1'b0);
    dir8("sat", 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0);
    dir8("max1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    dir8("pos_ovf", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);

    // Reset mid-stream discards the result of the inputs present at that edge.
    rst = 1'b1; a8 = 8'h12; b8 = 8'h34; ci8 = 1'b1;
    tick();
    chk("mid_rst_s", 64'(s8), 64'h0);
    chk("mid_rst_c", 64'(co8), 64'h0);
    rst = 1'b0;
    tick();
    chk("mid_rel_s", 64'(s8), 64'h47);
    prev9 = {co8 == 1'b1 ? 1'b1 : 1'b0, 8'h47};
    prev9 = 9'h047;

    // Back-to-back random sweep; outputs must hold until the next edge.
    for (int i = 0; i < 300; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
      #1;
      chk("hold8", 64'({co8, s8}), 64'(prev9));
      m9 = 9'(a8) + 9'(b8) + 9'(ci8);
      tick();
      chk("rnd8", 64'({co8, s8}), 64'(m9));
`ifdef CLA_OVERFLOW_EN
      chk("rnd8_v", 64'(v8), 64'(ovf(a8[7], b8[7], m9[7])));
`endif
      prev9 = m9;
    end

    prev14 = 14'h0000;
    for (int i = 0; i < 300; i++) begin
      a13 = 13'($urandom); b13 = 13'($urandom); ci13 = 1'($urandom);
      if (i == 0) begin a13 = '1; b13 = '0; ci13 = 1'b1; end
      if (i == 1) begin a13 = '1; b13 = '1; ci13 = 1'b1; end
      m14 = 14'(a13) + 14'(b13) + 14'(ci13);
      tick();
      chk("rnd13", 64'({co13, s13}), 64'(m14));
`ifdef CLA_OVERFLOW_EN
      chk("rnd13_v", 64'(v13), 64'(ovf(a13[12], b13[12], m14[12])));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
